// File: rtl/adder256_arb.sv
`default_nettype none
// ============================================================================
//  Module   : adder256_arb
//  Purpose  : Round-robin arbiter/sequencer sharing one 256-bit adder between
//             N requesters; one transaction in flight, watchdog on the adder.
//  Revision : 1.0 - initial release
// ============================================================================
module adder256_arb #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*256-1:0] req_a,
    input  logic [N*256-1:0] req_b,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     rsp_valid,
    output logic [255:0]     rsp_s,
    output logic             rsp_cout,
    output logic             rsp_err,
    input  logic [N-1:0]     rsp_ready,
    output logic [255:0]     add_a,
    output logic [255:0]     add_b,
    output logic             add_valid,
    output logic             add_rdy,
    input  logic [255:0]     add_s,
    input  logic             add_cout,
    input  logic             add_done
);

    localparam int            c_gw  = (N > 1) ? $clog2(N) : 1;
    localparam int            c_ww  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [N-1:0]  c_one = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_gw-1:0]   grant_q, grant_d;
    logic [c_gw-1:0]   last_q,  last_d;
    logic [c_ww-1:0]   wdog_q,  wdog_d;
    logic [255:0]      a_q, a_d, b_q, b_d, s_q, s_d;
    logic              cout_q, cout_d, err_q, err_d;

    logic [255:0]      w_a_arr [N];
    logic [255:0]      w_b_arr [N];
    logic              w_found;
    logic [c_gw-1:0]   w_pick;
    logic [c_gw-1:0]   w_idx;
    logic [N-1:0]      w_req_ready;
    logic [N-1:0]      w_grant_oh;

    // Unpack the flat operand buses into per-requester words.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_a_arr[gi] = req_a[256*gi +: 256];
        assign w_b_arr[gi] = req_b[256*gi +: 256];
    end

    // Round-robin pick: first valid requester searching upward from last_grant+1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = c_gw'((int'(last_q) + k) % N);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Next-state and grant logic for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wdog_d      = wdog_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        cout_d      = cout_q;
        err_d       = err_q;
        w_req_ready = '0;
        case (state_q)
            S_IDLE: begin
                // No grant pulse while reset is being held.
                if (w_found && reset) begin
                    w_req_ready[w_pick] = 1'b1;
                    grant_d             = w_pick;
                    a_d                 = w_a_arr[w_pick];
                    b_d                 = w_b_arr[w_pick];
                    wdog_d              = '0;
                    state_d             = S_BUSY;
                end
            end
            S_BUSY: begin
                // A real result wins over a watchdog expiry in the same cycle.
                if (add_done) begin
                    s_d     = add_s;
                    cout_d  = add_cout;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q == c_ww'(TIMEOUT - 1)) begin
                    s_d     = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= c_gw'(N - 1);
            wdog_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign w_grant_oh = c_one << grant_q;

    assign req_ready  = w_req_ready;
    assign add_valid  = (state_q == S_BUSY);
    assign add_rdy    = (state_q == S_BUSY);
    assign add_a      = (state_q == S_BUSY) ? a_q : '0;
    assign add_b      = (state_q == S_BUSY) ? b_q : '0;
    assign rsp_valid  = (state_q == S_RESP) ? w_grant_oh : '0;
    assign rsp_s      = (state_q == S_RESP) ? s_q : '0;
    assign rsp_cout   = (state_q == S_RESP) & cout_q;
    assign rsp_err    = (state_q == S_RESP) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_adder256_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder256_arb
//  Purpose  : Self-checking bench for adder256_arb with a latency-programmable
//             adder model and a round-robin reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder256_arb;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*256-1:0] req_a, req_b;
    logic [255:0]     rsp_s, add_a, add_b, add_s;
    logic             rsp_cout, rsp_err, add_valid, add_rdy, add_cout, add_done;

    int lat_cfg  = 3;
    int acnt     = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int m_last   = N - 1;

    always #5 clk = ~clk;

    adder256_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_valid (add_valid),
        .add_rdy   (add_rdy),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .add_done  (add_done)
    );

    // Adder model: result ready lat_cfg cycles after add_valid first rises;
    // a negative lat_cfg means the adder never completes.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};
    assign add_done = add_valid && (lat_cfg >= 0) && (acnt == lat_cfg);

    always @(posedge clk) begin
        if (!add_valid || (add_done && add_rdy)) acnt <= 0;
        else                                     acnt <= acnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[256*i +: 256] = rand256();
            req_b[256*i +: 256] = rand256();
        end
    endtask

    // Reference round-robin: first set bit above the last completed grant.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_cout, rsp_err, add_valid, add_rdy}, '0);
        chk({tag, "_rsp_s"}, rsp_s, '0);
        chk({tag, "_add_a"}, add_a, '0);
        chk({tag, "_add_b"}, add_b, '0);
    endtask

    // One full transaction starting in an IDLE cycle (called at posedge+1).
    task automatic do_txn(input logic [N-1:0] vmask, input int lat, input int hold);
        int           g, rc;
        logic [N-1:0] one1, gm, noise;
        logic [255:0] ea, eb;
        logic [256:0] ex;
        logic         err_exp;
        one1    = 1;
        g       = model_grant(vmask);
        gm      = one1 << g;
        ea      = req_a[256*g +: 256];
        eb      = req_b[256*g +: 256];
        err_exp = !(lat >= 0 && lat + 1 <= TIMEOUT);
        ex      = err_exp ? '0 : ({1'b0, ea} + {1'b0, eb});
        rc      = err_exp ? TIMEOUT + 1 : lat + 2;
        lat_cfg   = lat;
        req_valid = vmask;
        rsp_ready = (hold == 0) ? gm : '0;
        @(negedge clk);
        chk("grant", req_ready, gm);
        chk("grant_ctl", {add_valid, add_rdy, rsp_valid}, '0);
        @(posedge clk); #1;
        req_valid = '0;
        rand_ops();
        for (int c = 1; c < rc; c++) begin
            @(negedge clk);
            chk("busy_ctl", {add_valid, add_rdy, rsp_valid, req_ready}, {2'b11, {(2*N){1'b0}}});
            chk("busy_a", add_a, ea);
            chk("busy_b", add_b, eb);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, gm);
        chk("rsp_s", rsp_s, ex[255:0]);
        chk("rsp_cout", rsp_cout, ex[256]);
        chk("rsp_err", rsp_err, err_exp);
        chk("rsp_ctl", {add_valid, add_rdy, req_ready}, '0);
        repeat (hold) begin
            @(posedge clk); #1;
            noise     = N'($urandom);
            req_valid = noise | one1;
            rsp_ready = N'($urandom) & ~gm;
            @(negedge clk);
            chk("hold_valid", rsp_valid, gm);
            chk("hold_s", rsp_s, ex[255:0]);
            chk("hold_cout", {rsp_cout, rsp_err}, {ex[256], err_exp});
            chk("hold_no_grant", {req_ready, add_valid}, '0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rsp_ready = gm | (N'($urandom) & ~gm);
            @(negedge clk);
            chk("hold_last", rsp_valid, gm);
        end
        @(posedge clk); #1;
        rsp_ready = '0;
        req_valid = '0;
        m_last    = g;
    endtask

    initial begin
        logic [N-1:0] vm;
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        rand_ops();

        // Reset held for 10 cycles.
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_zero("idle_after_reset");
        @(posedge clk); #1;

        // Single request, L=3.
        req_a[256*2 +: 256] = 256'h1111111111111;
        req_b[256*2 +: 256] = 256'hffffffffffffffffffffffffffffffffffffffffff;
        do_txn(4'b0100, 3, 0);

        // Contention: all four requesting for 8 transactions.
        for (int t = 0; t < 8; t++) begin
            rand_ops();
            do_txn(4'b1111, int'($urandom_range(0, 5)), 0);
        end

        // Carry and backpressure.
        req_a = '1;
        req_b = '1;
        do_txn(4'b0001, 2, 5);

        // Random traffic with random latency and backpressure.
        for (int t = 0; t < 12; t++) begin
            rand_ops();
            vm = N'($urandom);
            if (vm == '0) vm = 4'b1000;
            do_txn(vm, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end

        // Idle with no request keeps outputs at zero.
        @(negedge clk);
        check_zero("idle_noreq");
        @(posedge clk); #1;

        // Timeout, then completion exactly at the timeout boundary, then normal.
        rand_ops();
        do_txn(4'b1000, -1, 0);
        rand_ops();
        do_txn(4'b0010, TIMEOUT - 1, 0);
        rand_ops();
        do_txn(4'b0100, 2, 0);

        // Reset mid-operation while the adder returns its result.
        rand_ops();
        lat_cfg   = 3;
        req_valid = 4'b0010;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (add_done) break;
        end
        chk("rm_done_seen", add_done, 1'b1);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_zero("rm_reset");
        end
        @(posedge clk); #1;
        reset  = 1'b1;
        @(negedge clk);
        check_zero("rm_release");
        @(posedge clk); #1;
        m_last = N - 1;
        rand_ops();
        do_txn(4'b1111, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder256_arb.md
# adder256_arb

Round-robin arbiter and sequencer that shares one `adder_256` instance between N requesters in the ECDSA datapath (point-add, point-double, scalar/nonce units). It accepts one request at a time, drives the adder's valid/ready interface, captures the 256-bit sum and carry, and returns them to the granted requester. A watchdog flags an adder that never completes. Only one transaction is ever in flight.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: cycles in BUSY before an error response is forced (≥ 2).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in N: request i holds operands valid.
- `req_a` in N*256: operand a, requester i at bits [256*i +: 256].
- `req_b` in N*256: operand b, same packing.
- `req_ready` out N: one-hot accept pulse, asserted only to the requester being granted.
- `rsp_valid` out N: one-hot response valid.
- `rsp_s` out 256: sum, shared by all requesters.
- `rsp_cout` out 1: carry out.
- `rsp_err` out 1: response caused by timeout.
- `rsp_ready` in N: requester i accepts its response.
- `add_a`, `add_b` out 256: to the adder's a/b inputs.
- `add_valid` out 1: to the adder's valid_in.
- `add_rdy` out 1: to the adder's ready_in (arbiter can take a result).
- `add_s` in 256, `add_cout` in 1: from the adder's s/cout.
- `add_done` in 1: from the adder's ready_out (result valid).

## Operation
- Adder contract: the adder samples a/b while `add_valid`=1. It presents s/cout with `add_done`=1 and holds them while `add_rdy`=0. A result transfers in a cycle with `add_done`&`add_rdy`.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any `req_valid` is set, grant g = first set bit searching upward from `last_grant`+1 modulo N.
  - In the same cycle, drive `req_ready[g]`=1 combinationally, register `req_a[g]`/`req_b[g]`, register g, clear the watchdog, and go to BUSY.
  - With no requests, stay in IDLE. All request/response outputs are 0.
- BUSY:
  - `add_valid`=1 and `add_rdy`=1. `add_a`/`add_b` come from registers and stay stable.
  - On `add_done`, register `add_s`/`add_cout`, set `rsp_err`=0, go to RESP.
  - If the watchdog reaches TIMEOUT-1 without `add_done`, go to RESP with `rsp_s`=0, `rsp_cout`=0, `rsp_err`=1.
  - `add_done` in the same cycle as the timeout takes priority (normal result).
- RESP:
  - `add_valid`=0, `add_rdy`=0. `rsp_valid[g]`=1, data held stable.
  - On `rsp_ready[g]`, set `last_grant`=g and go to IDLE.
  - `rsp_ready` on other bits is ignored.
- Arithmetic: the arbiter passes operands through unmodified and adds no width change. The sum is 256 bits plus 1 carry, exactly as returned by the adder.
- Fairness:
  - A requester that holds `req_valid` waits at most N-1 other transactions.
  - Deasserting `req_valid` before grant withdraws the request with no side effect.
  - Changing `req_a`/`req_b` after the grant cycle has no effect.
- Reset (`reset`=0 at a rising edge) overrides everything:
  - State goes to IDLE, `last_grant`=N-1 (requester 0 has first priority), watchdog=0.
  - All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_s`, `rsp_cout`, `rsp_err`, `add_a`, `add_b`, `add_valid`, `add_rdy`.
  - A reset in BUSY or RESP drops the transaction with no response.
  - An adder result arriving after reset is ignored, because `add_rdy`=0 in IDLE.

## Timing
- Cycle 0: IDLE, grant and `req_ready[g]` pulse (exactly one cycle).
- Cycle 1: BUSY, `add_valid`=1.
- If the adder asserts `add_done` in cycle 1+L, `rsp_valid[g]` rises in cycle 2+L.
- With `rsp_ready` already high, IDLE returns in cycle 3+L and the next grant can occur that cycle. Throughput is one transaction per L+3 cycles.
- Timeout: `rsp_valid`=1 with `rsp_err`=1 in cycle TIMEOUT+1 after grant.
- `add_valid` falls in the cycle after the `add_done`&`add_rdy` handshake.
- `req_ready` is never asserted outside IDLE.
- `rsp_valid` has at most one bit set. `req_ready` has at most one bit set.

## Test plan
- Reset: hold `reset`=0 for 10 cycles, then release. Required: all outputs 0, `add_valid`=0.
- Single request: `req_valid`=4'b0100, a=256'h1111111111111, b=256'hffff…ff (42 f's), adder L=3, `rsp_ready`=1.
  - Required: `req_ready`=4'b0100 at cycle 0, `add_valid` cycles 1–4, `rsp_valid`=4'b0100 at cycle 5.
  - `rsp_s`=a+b (=256'h1000000000000000000000000000001111111111110), `rsp_cout`=0.
- Contention: `req_valid`=4'b1111 held for 8 transactions. Required grant order 0,1,2,3,0,1,2,3; each response carries its own operand sum.
- Carry and backpressure: a=b=2^256-1, hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_valid` and `rsp_s`=2^256-2, `rsp_cout`=1 stable throughout; no new grant until `rsp_ready`=1.
- Timeout: the adder never asserts `add_done`, TIMEOUT=64. Required: `rsp_err`=1, `rsp_s`=0 at cycle 65 after grant; the next request then completes normally with `rsp_err`=0.
- Reset mid-operation: assert `reset`=0 in BUSY while the adder returns `add_done`. Required: no `rsp_valid`; after release, requester 0 is granted first.
